// File: rtl/maincu_if.sv
// Bundle of the control unit's instruction/memory inputs and datapath control outputs.
// The control unit drives outputs through master; the datapath side uses slave.
interface maincu_if #(
    parameter int OPW = 4
);
    logic [OPW-1:0] opcode;
    logic           mem_ready;
    logic           pc_write;
    logic           pc_write_cond;
    logic           i_or_d;
    logic           mem_read;
    logic           mem_write;
    logic           ir_write;
    logic           mem_to_reg;
    logic           reg_dst;
    logic           reg_write;
    logic           alu_src_a;
    logic [1:0]     alu_src_b;
    logic [1:0]     alu_op;
    logic [1:0]     pc_source;
    logic           retire;
    logic           illegal;
    logic [3:0]     state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, retire, illegal, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, retire, illegal, state
    );
endinterface

// File: rtl/maincu.sv
// Multicycle main control unit: sequences fetch/decode/execute/memory/writeback and
// drives datapath selects, write enables and the ALU op code for the ALU control unit.
//
// state  | meaning
// RST    | post-reset idle, all outputs low
// FETCH  | read instruction at PC, PC+4 (waits on mem_ready)
// DECODE | sample opcode, precompute branch target
// MEMADR | compute load/store address
// MEMRD  | data read (waits on mem_ready)
// MEMWB  | write loaded data to register file
// MEMWR  | data write (waits on mem_ready)
// EXEC   | R-type ALU operation
// ALUWB  | write ALU result to rd
// BRANCH | compare and conditionally load PC
// JUMP   | load jump target
// TRAP   | undefined opcode, one cycle
module maincu #(
    parameter int             OPW    = 4,
    parameter logic [OPW-1:0] OP_R   = 4'h0,
    parameter logic [OPW-1:0] OP_LW  = 4'h1,
    parameter logic [OPW-1:0] OP_SW  = 4'h2,
    parameter logic [OPW-1:0] OP_BEQ = 4'h3,
    parameter logic [OPW-1:0] OP_J   = 4'h4
) (
    input  logic     clk,
    input  logic     rst_n,
    maincu_if.master bus
);

    typedef enum logic [3:0] {
        RST    = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        TRAP   = 4'd11
    } state_e;

    state_e         state_q;
    state_e         state_d;
    logic [OPW-1:0] op_q;
    logic           rst_done_q;

    // rst_done_q keeps the FSM in RST for one full edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST;
            op_q       <= '0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
            if (state_q == DECODE)
                op_q <= bus.opcode;
        end
    end

    always_comb begin
        state_d           = RST;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        bus.retire        = 1'b0;
        bus.illegal       = 1'b0;

        case (state_q)
            RST: state_d = rst_done_q ? FETCH : RST;
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                state_d       = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_R:          state_d = EXEC;
                    OP_LW, OP_SW:  state_d = MEMADR;
                    OP_BEQ:        state_d = BRANCH;
                    OP_J:          state_d = JUMP;
                    default:       state_d = TRAP;
                endcase
            end
            MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (op_q == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                state_d      = bus.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.retire     = 1'b1;
                state_d        = FETCH;
            end
            MEMWR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                bus.retire    = bus.mem_ready;
                state_d       = bus.mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                state_d       = ALUWB;
            end
            ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                bus.retire    = 1'b1;
                state_d       = FETCH;
            end
            BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
                bus.retire        = 1'b1;
                state_d           = FETCH;
            end
            JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
                bus.retire    = 1'b1;
                state_d       = FETCH;
            end
            TRAP: begin
                bus.illegal = 1'b1;
                bus.retire  = 1'b1;
                state_d     = FETCH;
            end
            default: state_d = RST;
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_maincu.sv
// Directed-vector bench for maincu: stimulus pushes the expected per-cycle outputs,
// an independent monitor pops and compares each cycle.
module tb_maincu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    maincu_if bus ();

    maincu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       retire;
        logic       illegal;
    } vec_t;

    vec_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    stim_done = 1'b0;

    // Expected outputs for a state as written out in the control table.
    function automatic vec_t exp_vec(input logic [3:0] s, input logic mr);
        vec_t v;
        v = '0;
        v.st = s;
        case (s)
            4'd1:  begin v.mem_read = 1; v.alu_src_b = 2'b01; v.ir_write = mr; v.pc_write = mr; end
            4'd2:  v.alu_src_b = 2'b11;
            4'd3:  begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
            4'd4:  begin v.mem_read = 1; v.i_or_d = 1; end
            4'd5:  begin v.reg_write = 1; v.mem_to_reg = 1; v.retire = 1; end
            4'd6:  begin v.mem_write = 1; v.i_or_d = 1; v.retire = mr; end
            4'd7:  begin v.alu_src_a = 1; v.alu_op = 2'b10; end
            4'd8:  begin v.reg_write = 1; v.reg_dst = 1; v.retire = 1; end
            4'd9:  begin v.alu_src_a = 1; v.alu_op = 2'b01; v.pc_write_cond = 1;
                         v.pc_source = 2'b01; v.retire = 1; end
            4'd10: begin v.pc_write = 1; v.pc_source = 2'b10; v.retire = 1; end
            4'd11: begin v.illegal = 1; v.retire = 1; end
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic step(input logic mr, input logic [3:0] op, input logic [3:0] s,
                        input string nm);
        @(negedge clk);
        bus.mem_ready = mr;
        bus.opcode    = op;
        exp_q.push_back(exp_vec(s, mr));
        name_q.push_back(nm);
    endtask

    task automatic set_rst(input logic r, input string nm);
        @(negedge clk);
        rst_n = r;
        exp_q.push_back('0);
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        vec_t  e;
        vec_t  a;
        string n;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a = {bus.state, bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                     bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                     bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source, bus.retire,
                     bus.illegal};
                n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL %s: got state=%0d vec=%h, want state=%0d vec=%h",
                             n, a.st, a, e.st, e);
                end
            end
        end
    end

    initial begin : stim
        bus.mem_ready = 1'b1;
        bus.opcode    = 4'h0;

        set_rst(1'b0, "reset_hold");
        set_rst(1'b1, "reset_release");
        step(1, 4'h9, 4'd0, "rst_first_edge");

        // R-type, 4 cycles
        step(1, 4'h9, 4'd1, "r_fetch");
        step(1, 4'h0, 4'd2, "r_decode");
        step(1, 4'h3, 4'd7, "r_exec");
        step(1, 4'h4, 4'd8, "r_aluwb");

        // LW with two stall cycles in FETCH and MEMRD, opcode garbage elsewhere
        step(0, 4'h3, 4'd1, "lw_fetch_stall1");
        step(0, 4'h4, 4'd1, "lw_fetch_stall2");
        step(1, 4'hF, 4'd1, "lw_fetch_done");
        step(1, 4'h1, 4'd2, "lw_decode");
        step(1, 4'h2, 4'd3, "lw_memadr");
        step(0, 4'h2, 4'd4, "lw_memrd_stall1");
        step(0, 4'h0, 4'd4, "lw_memrd_stall2");
        step(1, 4'h2, 4'd4, "lw_memrd_done");
        step(1, 4'h2, 4'd5, "lw_memwb");

        // SW, no stall
        step(1, 4'h0, 4'd1, "sw_fetch");
        step(1, 4'h2, 4'd2, "sw_decode");
        step(1, 4'h1, 4'd3, "sw_memadr");
        step(1, 4'h1, 4'd6, "sw_memwr");

        // SW with one write stall: retire only on the completing cycle
        step(1, 4'h0, 4'd1, "sw2_fetch");
        step(1, 4'h2, 4'd2, "sw2_decode");
        step(1, 4'h1, 4'd3, "sw2_memadr");
        step(0, 4'h1, 4'd6, "sw2_memwr_stall");
        step(1, 4'h1, 4'd6, "sw2_memwr_done");

        // BEQ and J, 3 cycles each
        step(1, 4'h0, 4'd1, "beq_fetch");
        step(1, 4'h3, 4'd2, "beq_decode");
        step(1, 4'h4, 4'd9, "beq_branch");
        step(1, 4'h0, 4'd1, "j_fetch");
        step(1, 4'h4, 4'd2, "j_decode");
        step(1, 4'h3, 4'd10, "j_jump");

        // Illegal opcode, garbage after decode must not matter
        step(1, 4'h0, 4'd1, "ill_fetch");
        step(1, 4'hF, 4'd2, "ill_decode");
        step(1, 4'h0, 4'd11, "ill_trap");
        step(1, 4'h1, 4'd1, "ill_back_fetch");
        step(1, 4'h5, 4'd2, "ill5_decode");
        step(1, 4'h0, 4'd11, "ill5_trap");

        // Asynchronous reset during a stalled MEMRD
        step(1, 4'h0, 4'd1, "rlw_fetch");
        step(1, 4'h1, 4'd2, "rlw_decode");
        step(0, 4'h1, 4'd3, "rlw_memadr");
        step(0, 4'h1, 4'd4, "rlw_memrd_stall");
        set_rst(1'b0, "reset_mid_memrd");
        set_rst(1'b0, "reset_mid_hold");
        bus.mem_ready = 1'b1;
        set_rst(1'b1, "reset2_release");
        step(1, 4'h0, 4'd0, "rst2_first_edge");
        step(1, 4'h0, 4'd1, "rst2_fetch");
        step(1, 4'h4, 4'd2, "post_decode");
        step(1, 4'h0, 4'd10, "post_jump");

        stim_done = 1'b1;
    end

    initial begin : finisher
        wait (stim_done);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        #4;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

endmodule
